// File: rtl/z_result_writeback.sv
// z_result_writeback: captures the 64-bit ALU result into Z and writes it back
// over the 32-bit bus with a valid/ready handshake. MUL/DIV results also
// commit Zlow/Zhigh into the LO/HI special registers.
module z_result_writeback #(
    parameter int           WIDTH   = 32,
    parameter logic [4:0]   OP_MUL  = 5'b00011,
    parameter logic [4:0]   OP_DIV  = 5'b00100,
    parameter int           COUNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic [4:0]           opcode,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid,
    output logic                 bus_sel_hi,
    input  logic                 bus_ready,
    output logic [WIDTH-1:0]     lo_reg,
    output logic [WIDTH-1:0]     hi_reg,
    output logic                 busy,
    output logic                 done,
    output logic [COUNT_W-1:0]   result_count
);

    typedef enum logic [1:0] {IDLE, DRIVE_LO, DRIVE_HI, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   z;
    logic [4:0]           op_q;
    logic                 is_wide;

    assign is_wide = (op_q == OP_MUL) || (op_q == OP_DIV);

    // Bus word is selected from Z only, so alu_result never reaches the bus
    // combinationally; it reads 0 whenever nothing is being driven.
    assign bus_out = !bus_valid ? '0 :
                     bus_sel_hi ? z[2*WIDTH-1:WIDTH] : z[WIDTH-1:0];

    // Writeback FSM; all handshake/status outputs are registered with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            z            <= '0;
            op_q         <= '0;
            lo_reg       <= '0;
            hi_reg       <= '0;
            result_count <= '0;
            bus_valid    <= 1'b0;
            bus_sel_hi   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        z          <= alu_result;
                        op_q       <= opcode;
                        state      <= DRIVE_LO;
                        bus_valid  <= 1'b1;
                        bus_sel_hi <= 1'b0;
                        busy       <= 1'b1;
                        res_ready  <= 1'b0;
                    end
                end
                DRIVE_LO: begin
                    if (bus_ready) begin
                        if (is_wide) begin
                            lo_reg     <= z[WIDTH-1:0];
                            bus_sel_hi <= 1'b1;
                            state      <= DRIVE_HI;
                        end else begin
                            bus_valid  <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DRIVE_HI: begin
                    if (bus_ready) begin
                        hi_reg     <= z[2*WIDTH-1:WIDTH];
                        bus_valid  <= 1'b0;
                        bus_sel_hi <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Count wraps naturally at 2^COUNT_W.
                    result_count <= result_count + 1'b1;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    res_ready    <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_result_writeback.sv
// Bench for z_result_writeback: directed scenarios with literal expectations,
// then randomized traffic, all tracked by a word-queue reference model.
module tb_z_result_writeback;

    localparam int W  = 32;
    localparam int CW = 2;
    localparam logic [4:0] MUL = 5'b00011;
    localparam logic [4:0] DIV = 5'b00100;
    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] OR_ = 5'b00110;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [2*W-1:0]  alu_result = '0;
    logic [4:0]      opcode = '0;
    logic            res_valid = 1'b0;
    logic            res_ready;
    logic [W-1:0]    bus_out;
    logic            bus_valid;
    logic            bus_sel_hi;
    logic            bus_ready = 1'b0;
    logic [W-1:0]    lo_reg;
    logic [W-1:0]    hi_reg;
    logic            busy;
    logic            done;
    logic [CW-1:0]   result_count;

    int checks = 0;
    int errors = 0;

    z_result_writeback #(.WIDTH(W), .OP_MUL(MUL), .OP_DIV(DIV), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .opcode(opcode),
        .res_valid(res_valid), .res_ready(res_ready), .bus_out(bus_out),
        .bus_valid(bus_valid), .bus_sel_hi(bus_sel_hi), .bus_ready(bus_ready),
        .lo_reg(lo_reg), .hi_reg(hi_reg), .busy(busy), .done(done),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: a result is a list of bus words still to be accepted,
    // followed by one completion cycle.
    typedef struct {
        bit          hi;
        bit          commit;
        logic [W-1:0] data;
    } word_t;

    word_t          mq[$];
    bit             m_done = 1'b0;
    logic [W-1:0]   m_lo = '0;
    logic [W-1:0]   m_hi = '0;
    int             m_count = 0;

    // Compare DUT against the model mid-cycle, then advance the model with the
    // inputs the next rising edge will sample.
    always @(negedge clk) begin
        bit m_busy;
        m_busy = (mq.size() > 0) || m_done;
        chk("bus_valid", bus_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("bus_out", bus_out, mq[0].data);
            chk("bus_sel_hi", bus_sel_hi, mq[0].hi);
        end
        chk("done", done, m_done);
        chk("busy", busy, m_busy);
        chk("res_ready", res_ready, !m_busy);
        chk("lo_reg", lo_reg, m_lo);
        chk("hi_reg", hi_reg, m_hi);
        chk("result_count", result_count, m_count % (1 << CW));

        if (!reset) begin
            mq.delete();
            m_done = 1'b0; m_lo = '0; m_hi = '0; m_count = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_count++;
        end else if (mq.size() > 0) begin
            if (bus_ready) begin
                word_t w;
                w = mq.pop_front();
                if (w.commit) begin
                    if (w.hi) m_hi = w.data;
                    else      m_lo = w.data;
                end
                if (mq.size() == 0) m_done = 1'b1;
            end
        end else if (res_valid) begin
            bit wide;
            wide = (opcode == MUL) || (opcode == DIV);
            mq.push_back('{hi: 1'b0, commit: wide, data: alu_result[W-1:0]});
            if (wide) mq.push_back('{hi: 1'b1, commit: 1'b1, data: alu_result[2*W-1:W]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        chk("rst_res_ready", res_ready, 1'b1);
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_count", result_count, 0);

        // Narrow ADD
        alu_result = 64'h0000_0000_0000_000C; opcode = ADD; res_valid = 1'b1; bus_ready = 1'b1;
        cyc(); res_valid = 1'b0;
        chk("add_bus_out_n1", bus_out, 32'hC);
        chk("add_valid_n1", bus_valid, 1'b1);
        cyc();
        chk("add_done_n2", done, 1'b1);
        cyc();
        chk("add_ready_n3", res_ready, 1'b1);
        chk("add_count", result_count, 1);
        chk("add_lo", lo_reg, 0);
        chk("add_hi", hi_reg, 0);

        // Wide MUL
        alu_result = 64'hFFFF_FFFF_FFFF_FFFA; opcode = MUL; res_valid = 1'b1;
        cyc(); res_valid = 1'b0;
        chk("mul_lo_word", bus_out, 32'hFFFF_FFFA);
        chk("mul_sel_lo", bus_sel_hi, 1'b0);
        cyc();
        chk("mul_lo_reg", lo_reg, 32'hFFFF_FFFA);
        chk("mul_hi_word", bus_out, 32'hFFFF_FFFF);
        chk("mul_sel_hi", bus_sel_hi, 1'b1);
        cyc();
        chk("mul_done_n3", done, 1'b1);
        chk("mul_hi_reg", hi_reg, 32'hFFFF_FFFF);
        cyc();

        // Backpressure on DIV, with a competing request held while busy
        alu_result = 64'h1234_5678_9ABC_DEF0; opcode = DIV; res_valid = 1'b1; bus_ready = 1'b0;
        cyc();
        alu_result = 64'hDEAD_BEEF_0BAD_F00D; opcode = ADD;
        for (int i = 0; i < 3; i++) begin
            chk("bp_bus_out", bus_out, 32'h9ABC_DEF0);
            chk("bp_valid", bus_valid, 1'b1);
            chk("bp_lo_held", lo_reg, 32'hFFFF_FFFA);
            if (i == 2) bus_ready = 1'b1;
            cyc();
        end
        chk("bp_hi_word", bus_out, 32'h1234_5678);
        chk("bp_lo_reg", lo_reg, 32'h9ABC_DEF0);
        cyc();
        res_valid = 1'b0;
        chk("bp_done", done, 1'b1);
        chk("bp_hi_reg", hi_reg, 32'h1234_5678);
        cyc();
        chk("bp_count", result_count, 3);

        // Reset while driving Zhigh
        alu_result = 64'hAAAA_BBBB_CCCC_DDDD; opcode = MUL; res_valid = 1'b1; bus_ready = 1'b1;
        cyc(); res_valid = 1'b0;
        cyc();
        chk("rh_in_hi", bus_sel_hi, 1'b1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("rh_valid", bus_valid, 1'b0);
        chk("rh_ready", res_ready, 1'b1);
        chk("rh_lo", lo_reg, 0);
        chk("rh_hi", hi_reg, 0);
        chk("rh_count", result_count, 0);

        // Back-to-back OR results: count wraps 1,2,3,0
        alu_result = 64'h0000_0000_0000_00F0; opcode = OR_; res_valid = 1'b1; bus_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (!done && n < 10) begin cyc(); n++; end
            if (!done) chk("wrap_done_timeout", 0, 1);
            cyc();
            chk("wrap_count", result_count, (k + 1) % 4);
        end
        res_valid = 1'b0;
        cyc(); cyc();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom % 4;
            opcode = (r == 0) ? MUL : (r == 1) ? DIV : 5'($urandom % 32);
            alu_result = {$urandom, $urandom};
            res_valid = ($urandom % 3) != 0;
            bus_ready = ($urandom % 4) != 0;
            reset = ($urandom % 64) != 0;
            cyc();
        end
        reset = 1'b1; res_valid = 1'b0; bus_ready = 1'b1;
        repeat (6) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
